// File: rtl/pdp8_intctl.sv
// PDP-8 interrupt controller (device 00).
// Merges the per-device IOT responses onto the CPU bus and decodes the
// device-00 IOTs (SKON/ION/IOF/SRQ/CAF). It also implements the
// one-instruction ION delay, the registered interrupt request, the CAF
// clear pulse and a sticky bus-conflict flag.
module pdp8_intctl #(
  parameter int         NDEV = 4,
  parameter logic [3:0] F0   = 4'b0000,
  parameter logic [3:0] F1   = 4'b0001,
  parameter logic [3:0] F2   = 4'b0010,
  parameter logic [3:0] F3   = 4'b0011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iot,
  input  logic [3:0]      state,
  input  logic [11:0]     mb,
  input  logic [5:0]      io_select,
  input  logic [NDEV-1:0] dev_selected,
  input  logic [NDEV-1:0] dev_skip,
  input  logic [NDEV-1:0] dev_interrupt,
  input  logic            int_ack,
  output logic            io_selected,
  output logic            io_skip,
  output logic            interrupt_req,
  output logic            caf_clear,
  output logic            ion,
  output logic            bus_conflict
);

  localparam logic [2:0] FN_SKON = 3'd0;
  localparam logic [2:0] FN_ION  = 3'd1;
  localparam logic [2:0] FN_IOF  = 3'd2;
  localparam logic [2:0] FN_SRQ  = 3'd3;
  localparam logic [2:0] FN_CAF  = 3'd7;

  // ION has been executed; it moves into ion_dly at the next F0.
  logic       ion_pend;
  // Enable is armed for the F3 of the current instruction.
  logic       ion_dly;

  logic [2:0] fn;
  logic       in_f0;
  logic       in_f1;
  logic       in_f3;
  logic       own_dec;
  logic       own_sel;
  logic       own_skip;
  logic       any_int;
  logic       conflict;
  logic       do_caf;
  logic       do_off;
  logic       do_ion;

  // Only the IOT function field of mb is used; the F2 encoding is never
  // acted on because nothing in this block updates during F2.
  logic       unused_ok;
  assign unused_ok = ^{mb[11:3], F2};

  // True when more than one responder claims the current IOT.
  function automatic logic multi_select(input logic [NDEV-1:0] sel,
                                        input logic            own);
    int cnt;
    cnt = own ? 1 : 0;
    for (int i = 0; i < NDEV; i++) begin
      cnt = cnt + (sel[i] ? 1 : 0);
    end
    return (cnt > 1);
  endfunction

  // Device-00 decode and the merged combinational bus responses.
  always_comb begin
    fn       = mb[2:0];
    in_f0    = (state == F0);
    in_f1    = (state == F1);
    in_f3    = (state == F3);
    any_int  = |dev_interrupt;
    own_dec  = in_f1 && iot && (io_select == 6'o00);
    own_sel  = own_dec && (fn inside {FN_SKON, FN_ION, FN_IOF, FN_SRQ, FN_CAF});
    own_skip = own_dec && (((fn == FN_SKON) && ion) ||
                           ((fn == FN_SRQ) && any_int));
    conflict = in_f1 && iot && multi_select(dev_selected, own_sel);
    do_caf   = own_dec && (fn == FN_CAF);
    do_off   = own_dec && ((fn == FN_SKON) || (fn == FN_IOF) || (fn == FN_CAF));
    do_ion   = own_dec && (fn == FN_ION);

    io_selected = (|dev_selected) || own_sel;
    io_skip     = (|dev_skip) || own_skip;
  end

  // Interrupt enable chain: ION -> pend -> dly (F0) -> ion (F3).
  // int_ack beats every same-edge F0/F1/F3 update.
  always_ff @(posedge clk) begin
    if (reset) begin
      ion      <= 1'b0;
      ion_pend <= 1'b0;
      ion_dly  <= 1'b0;
    end else if (int_ack) begin
      ion      <= 1'b0;
      ion_pend <= 1'b0;
      ion_dly  <= 1'b0;
    end else if (do_off) begin
      ion      <= 1'b0;
      ion_pend <= 1'b0;
      ion_dly  <= 1'b0;
    end else begin
      if (do_ion) begin
        ion_pend <= 1'b1;
      end
      if (in_f0 && ion_pend) begin
        ion_pend <= 1'b0;
        ion_dly  <= 1'b1;
      end
      if (in_f3 && ion_dly) begin
        ion     <= 1'b1;
        ion_dly <= 1'b0;
      end
    end
  end

  // Interrupt request is re-evaluated only at F3 and held otherwise.
  always_ff @(posedge clk) begin
    if (reset || int_ack) begin
      interrupt_req <= 1'b0;
    end else if (in_f3) begin
      interrupt_req <= (ion || ion_dly) && any_int;
    end
  end

  // CAF pulse lasts one clock; conflict flag is sticky until CAF or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      caf_clear    <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      caf_clear <= do_caf;
      if (do_caf) begin
        bus_conflict <= 1'b0;
      end else if (conflict) begin
        bus_conflict <= 1'b1;
      end
    end
  end

endmodule
